// File: rtl/m_iter_unit.sv
// Iterative RISC-V M-extension unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
// Retires BITS_PER_CYCLE bits per cycle. Divide special cases finish in one cycle.
module m_iter_unit #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            hold,
    input  logic            flush,
    output logic            stallreq,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);

    localparam int ITER  = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] hi_q, lo_q, opnd_q;
    logic [2:0]      op_q;
    logic            neg_q;

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [XLEN-1:0] mul_pick(input logic [2*XLEN-1:0] p, input logic n,
                                                 input logic take_hi);
        logic [2*XLEN-1:0] s;
        s = n ? -p : p;
        return take_hi ? s[2*XLEN-1:XLEN] : s[XLEN-1:0];
    endfunction

    // Divide by zero: quotient all-ones, remainder = a. Signed overflow: quotient = a, remainder 0.
    function automatic logic [XLEN-1:0] special_value(input logic is_rem, input logic b_zero,
                                                      input logic [XLEN-1:0] dividend);
        if (b_zero)
            return is_rem ? dividend : {XLEN{1'b1}};
        return is_rem ? {XLEN{1'b0}} : dividend;
    endfunction

    logic signed [XLEN-1:0] a_s, b_s;
    logic                   a_sgn, b_sgn, a_neg, b_neg, neg_in;
    logic [XLEN-1:0]        mag_a, mag_b;
    logic                   accept, special, b_zero, last_iter;

    assign a_s = $signed(a);
    assign b_s = $signed(b);

    always_comb begin
        if (op[2]) begin
            a_sgn = !op[0];
            b_sgn = !op[0];
        end else begin
            a_sgn = (op[1:0] != 2'b11);
            b_sgn = !op[1];
        end
        a_neg  = a_sgn && (a_s < 0);
        b_neg  = b_sgn && (b_s < 0);
        mag_a  = neg_if(a, a_neg);
        mag_b  = neg_if(b, b_neg);
        // Remainder follows the dividend; everything else follows the product of signs.
        neg_in = (op[2] && op[1]) ? a_neg : (a_neg ^ b_neg);
    end

    assign b_zero    = (b == '0);
    assign special   = op[2] && (b_zero ||
                       (!op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == {XLEN{1'b1}})));
    assign accept    = (state == IDLE) && start && !flush;
    assign last_iter = (state == CALC) && (cnt == CNT_W'(1));

    // One iteration = BITS_PER_CYCLE radix-2 shift-add or restoring-subtract steps.
    logic [XLEN-1:0] hi_nx, lo_nx;
    logic [XLEN:0]   mac, rsh;

    always_comb begin
        hi_nx = hi_q;
        lo_nx = lo_q;
        mac   = '0;
        rsh   = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (op_q[2]) begin
                rsh   = {hi_nx, lo_nx[XLEN-1]};
                if (rsh >= {1'b0, opnd_q}) begin
                    hi_nx = XLEN'(rsh - {1'b0, opnd_q});
                    lo_nx = {lo_nx[XLEN-2:0], 1'b1};
                end else begin
                    hi_nx = rsh[XLEN-1:0];
                    lo_nx = {lo_nx[XLEN-2:0], 1'b0};
                end
            end else begin
                mac            = {1'b0, hi_nx} + (lo_nx[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
                {hi_nx, lo_nx} = {mac, lo_nx[XLEN-1:1]};
            end
        end
    end

    logic [XLEN-1:0] calc_res;

    always_comb begin
        if (op_q[2])
            calc_res = op_q[1] ? neg_if(hi_nx, neg_q) : neg_if(lo_nx, neg_q);
        else
            calc_res = mul_pick({hi_nx, lo_nx}, neg_q, op_q[1:0] != 2'b00);
    end

    always_comb begin
        state_nx     = state;
        stallreq     = 1'b0;
        busy         = (state != IDLE);
        result_valid = (state == DONE);
        unique case (state)
            IDLE: begin
                stallreq = start && !flush;
                if (accept)
                    state_nx = special ? DONE : CALC;
            end
            CALC: begin
                stallreq = 1'b1;
                if (last_iter)
                    state_nx = DONE;
            end
            DONE: begin
                if (!hold)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (flush)
            state_nx = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Datapath: a flush suppresses every register update, including the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            result <= '0;
        end else if (!flush) begin
            if (accept) begin
                if (special) begin
                    result <= special_value(op[1], b_zero, a);
                end else begin
                    hi_q   <= '0;
                    lo_q   <= mag_a;
                    opnd_q <= mag_b;
                    op_q   <= op;
                    neg_q  <= neg_in;
                    cnt    <= CNT_W'(ITER);
                end
            end else if (state == CALC) begin
                hi_q <= hi_nx;
                lo_q <= lo_nx;
                cnt  <= cnt - CNT_W'(1);
                if (last_iter)
                    result <= calc_res;
            end
        end
    end

endmodule

// File: tb/tb_m_iter_unit.sv
// Bench for m_iter_unit: three instances (32/1, 32/2, 64/4), scoreboard queue plus a monitor.
module tb_m_iter_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0]  start_v = '0, hold_v = '0, flush_v = '0;
    logic [2:0]  stall_v, busy_v, rv_v;
    logic [2:0]  op_v  [3];
    logic [63:0] a_v   [3];
    logic [63:0] b_v   [3];
    logic [63:0] res_v [3];

    for (genvar g = 0; g < 3; g++) begin : gu
        localparam int GXL = (g == 2) ? 64 : 32;
        localparam int GBP = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        logic [GXL-1:0] r_w;
        m_iter_unit #(.XLEN(GXL), .BITS_PER_CYCLE(GBP)) dut (
            .clk          (clk),
            .rst          (rst),
            .start        (start_v[g]),
            .op           (op_v[g]),
            .a            (a_v[g][GXL-1:0]),
            .b            (b_v[g][GXL-1:0]),
            .hold         (hold_v[g]),
            .flush        (flush_v[g]),
            .stallreq     (stall_v[g]),
            .busy         (busy_v[g]),
            .result_valid (rv_v[g]),
            .result       (r_w)
        );
        assign res_v[g] = 64'(r_w);
    end

    function automatic int ulen(input int u);
        return (u == 2) ? 64 : 32;
    endfunction

    function automatic int ubp(input int u);
        return (u == 0) ? 1 : ((u == 1) ? 2 : 4);
    endfunction

    function automatic logic [63:0] umask(input int u);
        return (ulen(u) == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    // Reference: exact integer arithmetic on wide signed values.
    function automatic logic [63:0] ref_op(input int xl, input logic [2:0] op,
                                           input logic [63:0] a, input logic [63:0] b);
        logic signed [129:0] m, ua, ub, sa, sb, v;
        logic [63:0] mask;
        mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        m  = 130'sd1 <<< xl;
        ua = $signed({66'd0, a & mask});
        ub = $signed({66'd0, b & mask});
        sa = a[xl-1] ? ua - m : ua;
        sb = b[xl-1] ? ub - m : ub;
        v  = 130'sd0;
        case (op)
            3'd0: v = sa * sb;
            3'd1: v = (sa * sb) >>> xl;
            3'd2: v = (sa * ub) >>> xl;
            3'd3: v = (ua * ub) >>> xl;
            3'd4: begin
                if (ub == 130'sd0) v = -130'sd1;
                else if (sa == -(m >>> 1) && sb == -130'sd1) v = sa;
                else v = sa / sb;
            end
            3'd5: v = (ub == 130'sd0) ? -130'sd1 : ua / ub;
            3'd6: begin
                if (ub == 130'sd0) v = sa;
                else if (sa == -(m >>> 1) && sb == -130'sd1) v = 130'sd0;
                else v = sa % sb;
            end
            default: v = (ub == 130'sd0) ? ua : ua % ub;
        endcase
        return v[63:0] & mask;
    endfunction

    typedef struct {
        int          u;
        logic [63:0] res;
        int          due;
        int          dur;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   st_from [3] = '{1, 1, 1};
    int   st_to   [3] = '{0, 0, 0};

    task automatic chk(input string name, input int u, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s unit=%0d actual=%h required=%h cyc=%0d", name, u, act, req, cyc);
        end
    endtask

    // Monitor: samples 2 time units after the falling edge, well clear of the rising edge.
    logic        prev_rv [3] = '{1'b0, 1'b0, 1'b0};
    logic [63:0] cur_res [3] = '{64'd0, 64'd0, 64'd0};
    int          cur_dur [3] = '{1, 1, 1};
    int          hi_cnt  [3] = '{0, 0, 0};

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            for (int u = 0; u < 3; u++) begin
                if (rst) begin
                    prev_rv[u] = 1'b0;
                    cur_res[u] = '0;
                end else begin
                    chk("stallreq", u, 64'(stall_v[u]), 64'(cyc >= st_from[u] && cyc <= st_to[u]));
                    if (rv_v[u] && !prev_rv[u]) begin
                        if (exp_q.size() == 0 || exp_q[0].u != u) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_valid unit=%0d actual=1 required=0 cyc=%0d", u, cyc);
                            cur_res[u] = res_v[u];
                            cur_dur[u] = 0;
                        end else begin
                            e = exp_q.pop_front();
                            chk("valid_cycle", u, 64'(cyc), 64'(e.due));
                            cur_res[u] = e.res;
                            cur_dur[u] = e.dur;
                        end
                        hi_cnt[u] = 0;
                    end
                    if (rv_v[u]) begin
                        hi_cnt[u]++;
                        chk("result", u, res_v[u], cur_res[u]);
                    end else begin
                        if (prev_rv[u] && cur_dur[u] > 0)
                            chk("done_cycles", u, 64'(hi_cnt[u]), 64'(cur_dur[u]));
                        chk("result_hold", u, res_v[u], cur_res[u]);
                    end
                    prev_rv[u] = rv_v[u];
                end
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy_v != 3'b000 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 0, 64'(busy_v), 64'd0);
    endtask

    task automatic do_op(input int u, input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] b, input int hold_n, input logic [63:0] expv);
        exp_t e;
        int   lat, n;
        logic spec;
        wait_idle();
        spec = op[2] && ((b == 64'd0) ||
               (!op[0] && a == (64'd1 << (ulen(u) - 1)) && b == umask(u)));
        lat   = spec ? 1 : ulen(u) / ubp(u) + 1;
        e.u   = u;
        e.res = expv;
        e.due = cyc + lat;
        e.dur = (hold_n > 0) ? hold_n : 1;
        exp_q.push_back(e);
        st_from[u] = cyc;
        st_to[u]   = cyc + lat - 1;
        op_v[u]    = op;
        a_v[u]     = a;
        b_v[u]     = b;
        hold_v[u]  = (hold_n > 0);
        start_v[u] = 1'b1;
        @(negedge clk);
        start_v[u] = 1'b0;
        if (hold_n > 0) begin
            n = 0;
            while (!rv_v[u] && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("valid_timeout", u, 64'(rv_v[u]), 64'd1);
            repeat (hold_n - 1) @(negedge clk);
            hold_v[u] = 1'b0;
        end
    endtask

    function automatic logic [63:0] pick(input int u);
        logic [63:0] v;
        case ($urandom_range(0, 6))
            0: v = 64'd0;
            1: v = 64'd1;
            2: v = 64'hFFFF_FFFF_FFFF_FFFF;
            3: v = 64'd1 << (ulen(u) - 1);
            4: v = 64'($urandom_range(0, 20));
            default: v = {$urandom, $urandom};
        endcase
        return v & umask(u);
    endfunction

    initial begin
        int T;
        for (int u = 0; u < 3; u++) begin
            op_v[u] = '0;
            a_v[u]  = '0;
            b_v[u]  = '0;
        end
        repeat (2) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            chk("reset_stallreq", u, 64'(stall_v[u]), 64'd0);
            chk("reset_busy", u, 64'(busy_v[u]), 64'd0);
            chk("reset_valid", u, 64'(rv_v[u]), 64'd0);
            chk("reset_result", u, res_v[u], 64'd0);
        end
        rst = 1'b0;

        do_op(0, 3'd0, 64'd7,          64'hFFFF_FFFD, 0, 64'hFFFF_FFEB);
        do_op(0, 3'd1, 64'h8000_0000,  64'h8000_0000, 0, 64'h4000_0000);
        do_op(0, 3'd3, 64'hFFFF_FFFF,  64'hFFFF_FFFF, 0, 64'hFFFF_FFFE);
        do_op(0, 3'd2, 64'hFFFF_FFFF,  64'hFFFF_FFFF, 0, 64'hFFFF_FFFF);
        do_op(0, 3'd4, 64'hFFFF_FFF9,  64'd2,         0, 64'hFFFF_FFFD);
        do_op(0, 3'd6, 64'hFFFF_FFF9,  64'd2,         0, 64'hFFFF_FFFF);
        do_op(0, 3'd5, 64'd100,        64'd7,         0, 64'd14);
        do_op(0, 3'd7, 64'd100,        64'd7,         0, 64'd2);
        do_op(1, 3'd4, 64'hFFFF_FFF9,  64'd2,         0, 64'hFFFF_FFFD);
        do_op(1, 3'd1, 64'h8000_0000,  64'h8000_0000, 0, 64'h4000_0000);
        do_op(0, 3'd4, 64'd5,          64'd0,         0, 64'hFFFF_FFFF);
        do_op(0, 3'd7, 64'd5,          64'd0,         0, 64'd5);
        do_op(0, 3'd4, 64'h8000_0000,  64'hFFFF_FFFF, 0, 64'h8000_0000);
        do_op(0, 3'd6, 64'h8000_0000,  64'hFFFF_FFFF, 0, 64'd0);
        do_op(2, 3'd5, 64'h8000_0000_0000_0000, 64'd3, 0, 64'h2AAA_AAAA_AAAA_AAAA);
        do_op(2, 3'd6, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'd0);

        // Hold in DONE for three cycles, then back to IDLE.
        do_op(0, 3'd5, 64'd100, 64'd7, 3, 64'd14);
        @(negedge clk);
        chk("idle_after_hold", 0, {62'd0, rv_v[0], busy_v[0]}, 64'd0);

        // Flush ten cycles into a DIV, then a fresh DIVU two cycles later.
        wait_idle();
        T = cyc;
        st_from[0] = T;
        st_to[0]   = T + 10;
        op_v[0] = 3'd4; a_v[0] = 64'hFFFF_FF9C; b_v[0] = 64'd7; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (9) @(negedge clk);
        flush_v[0] = 1'b1;
        @(negedge clk);
        flush_v[0] = 1'b0;
        chk("flush_busy", 0, 64'(busy_v[0]), 64'd0);
        chk("flush_stallreq", 0, 64'(stall_v[0]), 64'd0);
        chk("flush_cycle", 0, 64'(cyc), 64'(T + 11));
        do_op(0, 3'd5, 64'd9, 64'd3, 0, 64'd3);

        // start together with flush in IDLE is dropped.
        wait_idle();
        st_from[0] = 1;
        st_to[0]   = 0;
        op_v[0] = 3'd0; a_v[0] = 64'd3; b_v[0] = 64'd3; start_v[0] = 1'b1; flush_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        flush_v[0] = 1'b0;
        chk("flush_idle_busy", 0, 64'(busy_v[0]), 64'd0);

        for (int i = 0; i < 60; i++) begin
            int u, h;
            logic [2:0] op;
            logic [63:0] a, b;
            u  = $urandom_range(0, 2);
            op = 3'($urandom_range(0, 7));
            a  = pick(u);
            b  = pick(u);
            h  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            do_op(u, op, a, b, h, ref_op(ulen(u), op, a, b));
        end

        // Asynchronous reset pulse mid-CALC, with no clock edge while it is high.
        wait_idle();
        st_from[0] = cyc;
        st_to[0]   = cyc + 32;
        op_v[0] = 3'd0; a_v[0] = 64'd5; b_v[0] = 64'd3; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        st_to[0] = cyc - 1;
        #1 rst = 1'b1;
        #1;
        chk("arst_stallreq", 0, 64'(stall_v[0]), 64'd0);
        chk("arst_busy", 0, 64'(busy_v[0]), 64'd0);
        chk("arst_valid", 0, 64'(rv_v[0]), 64'd0);
        for (int u = 0; u < 3; u++)
            chk("arst_result", u, res_v[u], 64'd0);
        #1 rst = 1'b0;
        do_op(1, 3'd7, 64'd100, 64'd7, 0, 64'd2);

        wait_idle();
        repeat (5) @(negedge clk);
        chk("queue_empty", 0, 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
